// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by tag, commit from head.
// Optional ROB_WB_BYPASS_EN lets a head writeback commit in the same cycle.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ARCH_W-1:0] alloc_dest_arch,
  input  logic [PHYS_W-1:0] alloc_dest_phys,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [PTR_W-1:0]  wb_tag,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [ARCH_W-1:0] commit_dest_arch,
  output logic [PHYS_W-1:0] commit_dest_phys,
  input  logic              flush,
  output logic [PTR_W:0]    count
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [ARCH_W-1:0] r_arch [DEPTH];
  logic [PHYS_W-1:0] r_phys [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic w_alloc_fire;
  logic w_commit_fire;
  logic w_head_done;

`ifdef ROB_WB_BYPASS_EN
  assign w_head_done = r_done[r_head] || (wb_valid && (wb_tag == r_head));
`else
  assign w_head_done = r_done[r_head];
`endif

  assign alloc_ready      = (r_count != (PTR_W+1)'(DEPTH));
  assign alloc_tag        = r_tail;
  assign commit_valid     = r_valid[r_head] && w_head_done;
  assign commit_dest_arch = r_arch[r_head];
  assign commit_dest_phys = r_phys[r_head];
  assign count            = r_count;

  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = commit_valid && commit_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_arch[i] <= '0;
        r_phys[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_arch[i] <= '0;
        r_phys[i] <= '0;
      end
    end else begin
      if (wb_valid && r_valid[wb_tag]) begin
        r_done[wb_tag] <= 1'b1;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_arch[r_tail]  <= alloc_dest_arch;
        r_phys[r_tail]  <= alloc_dest_phys;
        r_tail          <= r_tail + PTR_W'(1);
      end
      // Later assignment wins, so a bypassed head never keeps done set.
      if (w_commit_fire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_alloc_fire)
                         - (PTR_W+1)'(w_commit_fire);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Expected values are hand-derived per step.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic [4:0] alloc_dest_arch;
  logic [5:0] alloc_dest_phys;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       wb_valid;
  logic [3:0] wb_tag;
  logic       commit_valid;
  logic       commit_ready;
  logic [4:0] commit_dest_arch;
  logic [5:0] commit_dest_phys;
  logic       flush;
  logic [4:0] count;

  int n_err = 0;
  int n_chk = 0;

  reorder_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_dest_arch  (alloc_dest_arch),
    .alloc_dest_phys  (alloc_dest_phys),
    .alloc_ready      (alloc_ready),
    .alloc_tag        (alloc_tag),
    .wb_valid         (wb_valid),
    .wb_tag           (wb_tag),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_dest_arch (commit_dest_arch),
    .commit_dest_phys (commit_dest_phys),
    .flush            (flush),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 0;
    alloc_dest_arch = '0;
    alloc_dest_phys = '0;
    wb_valid = 0;
    wb_tag = '0;
    commit_ready = 0;
    flush = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_tag", 32'(alloc_tag), 0);
    chk("rst_cvalid", 32'(commit_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_arch", 32'(commit_dest_arch), 0);
    chk("rst_phys", 32'(commit_dest_phys), 0);

    // three allocations
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1;
      alloc_dest_arch = 5'(i + 1);
      alloc_dest_phys = 6'(32 + i);
      #1;
      chk("a3_tag", 32'(alloc_tag), i);
      tick;
    end
    alloc_valid = 0;
    #1;
    chk("a3_count", 32'(count), 3);
    chk("a3_cvalid", 32'(commit_valid), 0);

    // out-of-order writeback, in-order commit
    commit_ready = 1;
    wb_valid = 1;
    wb_tag = 4'd1;
    #1;
    chk("wb1_cvalid", 32'(commit_valid), 0);
    tick;
    wb_tag = 4'd0;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("wb0_cvalid", 32'(commit_valid), 1);
    chk("c0_arch", 32'(commit_dest_arch), 1);
    chk("c0_phys", 32'(commit_dest_phys), 32);
`else
    chk("wb0_cvalid", 32'(commit_valid), 0);
    tick;
    wb_valid = 0;
    #1;
    chk("c0_cvalid", 32'(commit_valid), 1);
    chk("c0_arch", 32'(commit_dest_arch), 1);
    chk("c0_phys", 32'(commit_dest_phys), 32);
`endif
    tick;
    wb_valid = 0;
    #1;
    chk("c1_cvalid", 32'(commit_valid), 1);
    chk("c1_arch", 32'(commit_dest_arch), 2);
    chk("c1_phys", 32'(commit_dest_phys), 33);
    tick;
    #1;
    chk("c2_cvalid", 32'(commit_valid), 0);
    chk("c2_count", 32'(count), 1);
    commit_ready = 0;

    // fill to full, then commit with a blocked allocation
    pulse_reset;
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1;
      alloc_dest_arch = 5'(i + 1);
      alloc_dest_phys = 6'(32 + i);
      #1;
      chk("fill_tag", 32'(alloc_tag), i);
      tick;
    end
    alloc_valid = 0;
    #1;
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_count", 32'(count), 16);
    wb_valid = 1;
    wb_tag = 4'd0;
    tick;
    wb_valid = 0;
    alloc_valid = 1;
    alloc_dest_arch = 5'd31;
    alloc_dest_phys = 6'd63;
    commit_ready = 1;
    #1;
    chk("full_cvalid", 32'(commit_valid), 1);
    chk("full_ready2", 32'(alloc_ready), 0);
    tick;
    alloc_valid = 0;
    commit_ready = 0;
    #1;
    chk("post_count", 32'(count), 15);
    chk("post_ready", 32'(alloc_ready), 1);
    chk("post_tag", 32'(alloc_tag), 0);

    // stalled commit holds outputs
    wb_valid = 1;
    wb_tag = 4'd1;
    tick;
    wb_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_cvalid", 32'(commit_valid), 1);
      chk("stall_arch", 32'(commit_dest_arch), 2);
      chk("stall_phys", 32'(commit_dest_phys), 33);
      chk("stall_count", 32'(count), 15);
      tick;
    end
    commit_ready = 1;
    tick;
    commit_ready = 0;
    #1;
    chk("stall_done_cnt", 32'(count), 14);
    chk("stall_done_cv", 32'(commit_valid), 0);

    // flush beats alloc, writeback and commit
    pulse_reset;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1;
      alloc_dest_arch = 5'(i + 7);
      alloc_dest_phys = 6'(i + 40);
      tick;
    end
    alloc_valid = 0;
    wb_valid = 1;
    wb_tag = 4'd0;
    tick;
    flush = 1;
    wb_tag = 4'd1;
    alloc_valid = 1;
    commit_ready = 1;
    tick;
    flush = 0;
    wb_valid = 0;
    alloc_valid = 0;
    commit_ready = 0;
    #1;
    chk("fl_count", 32'(count), 0);
    chk("fl_cvalid", 32'(commit_valid), 0);
    chk("fl_tag", 32'(alloc_tag), 0);
    chk("fl_arch", 32'(commit_dest_arch), 0);

    // async reset between edges
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1;
      alloc_dest_arch = 5'(i + 3);
      alloc_dest_phys = 6'(i + 50);
      tick;
    end
    alloc_valid = 0;
    wb_valid = 1;
    wb_tag = 4'd0;
    tick;
    wb_valid = 0;
    #1;
    chk("ar_pre_cv", 32'(commit_valid), 1);
    chk("ar_pre_cnt", 32'(count), 3);
    reset = 1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_cvalid", 32'(commit_valid), 0);
    chk("ar_tag", 32'(alloc_tag), 0);
    reset = 0;

    // alloc and writeback to same tag: writeback ignored
    tick;
    alloc_valid = 1;
    alloc_dest_arch = 5'd9;
    alloc_dest_phys = 6'd20;
    wb_valid = 1;
    wb_tag = 4'd0;
    tick;
    alloc_valid = 0;
    wb_valid = 0;
    #1;
    chk("same_cv", 32'(commit_valid), 0);
    chk("same_cnt", 32'(count), 1);

    // writeback to head: same-cycle commit only with bypass
    commit_ready = 0;
    wb_valid = 1;
    wb_tag = 4'd0;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("byp_cv", 32'(commit_valid), 1);
`else
    chk("byp_cv", 32'(commit_valid), 0);
`endif
    commit_ready = 1;
    tick;
    wb_valid = 0;
    commit_ready = 0;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("byp_cnt", 32'(count), 0);
    chk("byp_cv2", 32'(commit_valid), 0);
`else
    chk("byp_cnt", 32'(count), 1);
    chk("byp_cv2", 32'(commit_valid), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of the register-rename stage.
- Each renamed instruction gets a circular-buffer entry holding its destination architectural and physical registers; the entry index is returned as a tag.
- Execution writes back by tag. Entries commit strictly in program order once complete.
- Commit outputs feed the architectural commit and free-list recycling logic.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2.
- PTR_W, 4, log2(DEPTH); width of tags and pointers.
- ARCH_W, 5, architectural register index width.
- PHYS_W, 6, physical register index width.

Ports:
- clk  input  1  Clock; all state changes on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- alloc_valid  input  1  Renamed instruction present this cycle.
- alloc_dest_arch  input  ARCH_W  Destination architectural register.
- alloc_dest_phys  input  PHYS_W  Destination physical register from rename.
- alloc_ready  output  1  Buffer not full; allocation accepted.
- alloc_tag  output  PTR_W  Tail index; tag assigned to the allocating instruction.
- wb_valid  input  1  Execution completion strobe.
- wb_tag  input  PTR_W  Tag of the completing instruction.
- commit_valid  output  1  Head entry is complete and retirable.
- commit_ready  input  1  Consumer accepts the commit.
- commit_dest_arch  output  ARCH_W  Head entry architectural destination.
- commit_dest_phys  output  PHYS_W  Head entry physical destination.
- flush  input  1  Synchronous discard of all entries.
- count  output  PTR_W+1  Number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Entry state: valid, done, arch, phys.
- Reset clears all valid/done bits, head=0, tail=0, count=0. As a result:
  - alloc_ready=1, alloc_tag=0, commit_valid=0, count=0.
  - commit_dest_arch and commit_dest_phys read entry 0, which is cleared to 0.
- Reset mid-operation discards every entry immediately, without waiting for a clock edge.
- alloc_ready = (count != DEPTH). It is computed from registered count only, so a full buffer does not accept an allocation even in a cycle where a commit fires.
- Allocation fire = alloc_valid && alloc_ready:
  - Entry[tail] gets valid=1, done=0, arch, phys.
  - tail advances by 1 and wraps from DEPTH-1 to 0.
  - alloc_tag is the tail value before the increment.
- Writeback: when wb_valid=1 and entry[wb_tag].valid=1, set done. Writeback to an invalid entry is ignored. A repeated writeback has no further effect.
- commit_valid = entry[head].valid && entry[head].done, using registered state. commit_dest_arch and commit_dest_phys are combinational reads of entry[head].
- Commit fire = commit_valid && commit_ready:
  - Clear entry[head].valid and entry[head].done.
  - head advances by 1 and wraps.
- Minimum latency from writeback to commit_valid is 1 cycle.
- A stalled commit holds all commit outputs stable until commit_ready is asserted.
- count next = count + alloc_fire - commit_fire. Simultaneous allocation and commit leaves count unchanged. Width PTR_W+1 holds the value DEPTH.
- Empty (count=0): commit_valid=0.
- Allocation and writeback to the same tag in the same cycle: writeback is ignored, because the entry is not yet valid.
- flush=1 at the clock edge has the same effect as reset. It has priority over allocation, writeback and commit in that cycle, and no commit fires.
- Committed entries with arch=0 are still reported; the consumer filters them.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined:
  - commit_valid also asserts when entry[head].valid=1, wb_valid=1 and wb_tag==head.
  - This gives 0-cycle writeback-to-commit latency for the head entry and adds a combinational path from wb_* to commit_valid.
  - If the head commits in that cycle, the entry is cleared; done must not remain set on it.
- Undefined: commit_valid uses registered done only, as specified in Behaviour.

Test Plan:
- Reset, then 3 allocations (arch 1/2/3, phys 32/33/34) -> alloc_tag 0,1,2; count=3; commit_valid=0.
- Writeback tag 1, then tag 0, with commit_ready=1 -> commits arch 1/phys 32 then arch 2/phys 33 on consecutive cycles; commit never precedes the tag-0 writeback; count=1.
- Fill 16 entries -> alloc_ready=0; in the same cycle, alloc_valid=1 plus commit of the completed head -> no allocation; count goes 16 to 15; next cycle alloc_ready=1 and alloc_tag=0 (wrap).
- Completed head with commit_ready=0 for 4 cycles -> commit_valid and commit_dest_* held stable; count unchanged.
- flush with 5 entries, wb_valid and alloc_valid all asserted -> next cycle count=0, commit_valid=0, alloc_tag=0.
- Async reset mid-cycle with 3 entries -> outputs cleared before the next edge. With ROB_WB_BYPASS_EN defined, writeback to the head tag -> commit_valid=1 in the same cycle.
